// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline control blocks.
package mips_pipe_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hcu_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Inc,
    output logic [W-1:0] Count
);

    logic [W-1:0] r_count;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_count <= '0;
        end else if (Inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign Count = r_count;

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use / branch hazard detection with a stall sequencer for branches resolved in ID.
module hazard_control_unit
    import mips_pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [REG_W-1:0] ID_Rs,
    input  logic [REG_W-1:0] ID_Rt,
    input  logic             ID_Uses_Rt,
    input  logic             ID_Is_Branch,
    input  logic             Branch_Taken,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_RegWrite,
    input  logic [REG_W-1:0] ID_EX_WriteReg,
    input  logic             EX_MEM_MemRead,
    input  logic [REG_W-1:0] EX_MEM_WriteReg,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             Hazard_Out,
    output logic [CNT_W-1:0] Stall_Cycles,
    output logic [CNT_W-1:0] Flush_Count
);

    hcu_state_t  r_state;
    logic [1:0]  r_remain;
    logic [1:0]  w_need;
    logic        w_src_ex;
    logic        w_src_mem;
    logic        w_stall;
    logic        w_flush;

    function automatic logic f_match(input logic [REG_W-1:0] src, input logic [REG_W-1:0] dst);
        return (dst != REG_ZERO) && (src == dst);
    endfunction

    assign w_src_ex  = f_match(ID_Rs, ID_EX_WriteReg)
                     | (ID_Uses_Rt & f_match(ID_Rt, ID_EX_WriteReg));
    assign w_src_mem = f_match(ID_Rs, EX_MEM_WriteReg)
                     | (ID_Uses_Rt & f_match(ID_Rt, EX_MEM_WriteReg));

    // Load cases are tested first so the larger requirement wins on overlap.
    always_comb begin
        w_need = 2'd0;
        if (r_state == RUN) begin
            if (ID_EX_MemRead && w_src_ex) begin
                w_need = ID_Is_Branch ? 2'd2 : 2'd1;
            end else if (ID_Is_Branch &&
                         ((ID_EX_RegWrite && w_src_ex) || (EX_MEM_MemRead && w_src_mem))) begin
                w_need = 2'd1;
            end
        end
    end

    assign w_stall = (r_state == STALL) || (w_need != 2'd0);
    assign w_flush = !Reset && !w_stall && ID_Is_Branch && Branch_Taken;

    always_comb begin
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        Hazard_Out  = 1'b0;
        if (!Reset) begin
            PC_Write    = !w_stall;
            IF_ID_Write = !w_stall;
            IF_ID_Flush = w_flush;
            Hazard_Out  = !w_stall;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= RUN;
            r_remain <= 2'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_need == 2'd2) begin
                        r_state  <= STALL;
                        r_remain <= 2'd1;
                    end
                end
                STALL: begin
                    r_remain <= r_remain - 2'd1;
                    if (r_remain <= 2'd1) begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state  <= RUN;
                    r_remain <= 2'd0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .Inc   (w_stall && !Reset),
        .Count (Stall_Cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .Inc   (w_flush),
        .Count (Flush_Count)
    );

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Hazard detection and stall/flush sequencer for the 5-stage MIPS pipeline. It examines the instruction in ID against the instructions in ID/EX and EX/MEM. It drives the PC and IF/ID write enables, the IF/ID flush, and `Hazard_Out`, which is the select consumed directly by the downstream control-signal bubble mux (0 = insert bubble, 1 = pass control). A small FSM holds multi-cycle stalls for branches resolved in ID. Saturating counters record stall and flush activity.

## Interface
Parameters:
- `CNT_W`, 16, width of the performance counters.

Ports:
- `Clk`  input  1  pipeline clock; all state updates on rising edge.
- `Reset`  input  1  synchronous, active-high.
- `ID_Rs`  input  5  rs field of the instruction in ID.
- `ID_Rt`  input  5  rt field of the instruction in ID.
- `ID_Uses_Rt`  input  1  ID instruction reads rt (R-type, beq, sw).
- `ID_Is_Branch`  input  1  ID instruction is beq (compared in ID).
- `Branch_Taken`  input  1  ID comparator result, valid only when `ID_Is_Branch`.
- `ID_EX_MemRead`  input  1  instruction in EX is a load.
- `ID_EX_RegWrite`  input  1  instruction in EX writes a register.
- `ID_EX_WriteReg`  input  5  destination register of the EX instruction (after RegDst).
- `EX_MEM_MemRead`  input  1  instruction in MEM is a load.
- `EX_MEM_WriteReg`  input  5  destination register of the MEM instruction.
- `PC_Write`  output  1  1 = PC updates.
- `IF_ID_Write`  output  1  1 = IF/ID register loads.
- `IF_ID_Flush`  output  1  1 = IF/ID loads a NOP (taken branch).
- `Hazard_Out`  output  1  bubble-mux select; 0 = zero ID/EX control, 1 = pass.
- `Stall_Cycles`  output  CNT_W  saturating count of bubble cycles.
- `Flush_Count`  output  CNT_W  saturating count of flushes.

## Operation
- A source "matches" a destination when the destination is nonzero and the two fields are equal. `ID_Rt` participates only if `ID_Uses_Rt` is set. Register 0 never causes a hazard.
- Stall requirement `need` is evaluated combinationally in state RUN only:
  - EX is a load matching an ID source, and the ID instruction is a branch: need = 2.
  - EX is a load matching an ID source, and the ID instruction is not a branch (load-use): need = 1.
  - EX writes a register (non-load) matching a source of an ID branch: need = 1.
  - MEM is a load matching a source of an ID branch: need = 1.
  - Otherwise need = 0.
  - When several cases hold, the largest need wins.
- FSM states:
  - RUN: `need` > 0 means stall this cycle. If need = 2, go to STALL with `Remain` = 1. If need = 1, stay in RUN; the next cycle is re-evaluated with the bubble now in EX.
  - STALL: stall this cycle unconditionally. Detection and `Branch_Taken` are ignored. Decrement `Remain`; go to RUN when `Remain` reaches 0.
- Stall cycle outputs: `PC_Write` = 0, `IF_ID_Write` = 0, `Hazard_Out` = 0, `IF_ID_Flush` = 0.
- Non-stall cycle outputs: `PC_Write` = 1, `IF_ID_Write` = 1, `Hazard_Out` = 1.
  - `IF_ID_Flush` = `ID_Is_Branch & Branch_Taken`.
- A taken branch during a stall cycle is not acted on. It is acted on in the first non-stall cycle, when the comparator operands are valid.
- Counters:
  - `Stall_Cycles` increments once per stall cycle.
  - `Flush_Count` increments once per flush cycle.
  - Both saturate at all-ones and do not wrap.

## Timing
- Control outputs (`PC_Write`, `IF_ID_Write`, `IF_ID_Flush`, `Hazard_Out`) are combinational from the inputs and state, in the same cycle. Zero latency is required because the bubble mux and the write enables act in the detecting cycle.
- State, `Remain` and counters are registered and update on the rising edge of `Clk`.
- Reset values:
  - State = RUN, `Remain` = 0, `Stall_Cycles` = 0, `Flush_Count` = 0.
  - While `Reset` is high, outputs are forced to `PC_Write` = 1, `IF_ID_Write` = 1, `IF_ID_Flush` = 0, `Hazard_Out` = 0. The pipeline fills with bubbles during reset.
- Reset asserted mid-STALL abandons the stall. The first cycle after deassertion is RUN.
- The maximum stall length is 2 consecutive cycles. STALL never lasts longer than 1 cycle.

## Structure
- A shared package `mips_pipe_pkg` holds:
  - the FSM state encoding (RUN = 1'b0, STALL = 1'b1);
  - `REG_ZERO` = 5'd0;
  - the register-field width constant `REG_W` = 5.
- Sub-module `sat_counter` (parameter `W`; ports `Clk`, `Reset`, `Inc`, `Count`) is instantiated twice, once per performance counter.
- Match logic is a local function; no further hierarchy.

## Test plan
- Load-use: EX = lw $t0 (`ID_EX_MemRead`=1, `ID_EX_WriteReg`=8), ID = add using rs=8. Required: exactly 1 cycle with `Hazard_Out`=0 and `PC_Write`=0, then normal flow; `Stall_Cycles`=1.
- Zero register: EX = lw writing register 0, ID rs=0. Required: no stall; `Hazard_Out`=1 every cycle.
- Branch after load: EX = lw $t1 (reg 9), ID = beq with rt=9, `Branch_Taken`=1 throughout. Required: 2 stall cycles (RUN→STALL→RUN). `IF_ID_Flush`=1 only in cycle 3. `Stall_Cycles`=2, `Flush_Count`=1.
- Branch after ALU op: EX = add writing reg 10, ID = beq with rs=10. Required: 1 stall cycle. A taken branch in the next cycle gives `IF_ID_Flush`=1.
- Reset mid-stall: enter STALL, then assert `Reset` for 1 cycle. Required: during reset `Hazard_Out`=0 and `PC_Write`=1; after release state is RUN and both counters read 0.
- Saturation: force `Stall_Cycles` to 16'hFFFE, then apply 3 load-use stalls. Required: count stops at 16'hFFFF.
